// File: rtl/tomasulo_pkg.sv
// ---------------------------------------------------------------------------
// tomasulo_pkg
// Shared definitions for the Tomasulo front end: ALU function codes,
// default datapath widths and the reservation-station entry layout.
// No ports (package).
// ---------------------------------------------------------------------------
package tomasulo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ROB_W  = 3;
    localparam int DEF_RD_W   = 4;

    localparam logic [3:0] FUNC_ADD = 4'b0000;
    localparam logic [3:0] FUNC_SUB = 4'b0001;
    localparam logic [3:0] FUNC_MUL = 4'b0010;
    localparam logic [3:0] FUNC_DIV = 4'b0011;

    // One reservation-station slot at the default widths. qN is the producer
    // ROB tag and is only meaningful while rNok is low.
    typedef struct packed {
        logic                  valid;
        logic [3:0]            func;
        logic [DEF_RD_W-1:0]   rd;
        logic [DEF_ROB_W-1:0]  rob;
        logic                  r1ok;
        logic [DEF_DATA_W-1:0] v1;
        logic [DEF_ROB_W-1:0]  q1;
        logic                  r2ok;
        logic [DEF_DATA_W-1:0] v2;
        logic [DEF_ROB_W-1:0]  q2;
    } rs_entry_t;

endpackage

// File: rtl/age_select.sv
// ---------------------------------------------------------------------------
// age_select
// Age matrix for the reservation station plus an oldest-ready picker.
// Ports:
//   clk, rst_n  : clock / async active-low reset
//   alloc       : an entry is being written this edge
//   alloc_oh    : one-hot slot being written
//   live        : entries that stay valid across this edge (excludes the one
//                 being dispatched)
//   ready       : entries eligible for dispatch
//   grant       : one-hot oldest ready entry (zero if none ready)
// ---------------------------------------------------------------------------
module age_select #(
    parameter int NUM_RS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc,
    input  logic [NUM_RS-1:0] alloc_oh,
    input  logic [NUM_RS-1:0] live,
    input  logic [NUM_RS-1:0] ready,
    output logic [NUM_RS-1:0] grant
);

    // older[i][j] set means entry j is older than entry i.
    logic [NUM_RS-1:0] older [NUM_RS];

    // A new entry is younger than everything still live, and no existing
    // entry may regard it as older, so its column is cleared. This keeps
    // every pair of valid entries strictly ordered, which makes the grant
    // one-hot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RS; i++) older[i] <= '0;
        end else if (alloc) begin
            for (int i = 0; i < NUM_RS; i++) begin
                if (alloc_oh[i]) older[i] <= live & ~alloc_oh;
                else             older[i] <= older[i] & ~alloc_oh;
            end
        end
    end

    // An entry wins when it is ready and no ready entry is older than it.
    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_RS; i++)
            grant[i] = ready[i] && ((older[i] & ready) == '0);
    end

endmodule

// File: rtl/rs_dispatch_sched.sv
// ---------------------------------------------------------------------------
// rs_dispatch_sched
// Reservation-station scheduler in front of a single shared execute unit.
// Buffers issued ALU ops, snoops the CDB for pending operand tags, and
// dispatches the oldest ready op whenever the exec unit is free or in its
// last busy cycle.
// Ports:
//   clk1, rst_n                  : clock / async active-low reset
//   iss_*                        : issue handshake and operands
//   cdb_valid/cdb_tag/cdb_data   : common data bus broadcast
//   flush                        : discard all buffered entries
//   ex_*                         : registered dispatch to the exec unit
//   ex_busy                      : exec unit occupied
//   rs_count                     : occupied entries
// Optional (macro RS_STATS_EN): stat_dispatched, stat_stall saturating
// 16-bit counters.
// ---------------------------------------------------------------------------
import tomasulo_pkg::*;

module rs_dispatch_sched #(
    parameter int NUM_RS  = 4,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ROB_W   = DEF_ROB_W,
    parameter int RD_W    = DEF_RD_W,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 4,
    localparam int CNT_OUT_W = $clog2(NUM_RS + 1)
) (
    input  logic                 clk1,
    input  logic                 rst_n,
    input  logic                 iss_valid,
    output logic                 iss_ready,
    input  logic [3:0]           iss_func,
    input  logic [RD_W-1:0]      iss_rd,
    input  logic [ROB_W-1:0]     iss_rob,
    input  logic                 iss_r1ok,
    input  logic                 iss_r2ok,
    input  logic [DATA_W-1:0]    iss_v1,
    input  logic [DATA_W-1:0]    iss_v2,
    input  logic [ROB_W-1:0]     iss_q1,
    input  logic [ROB_W-1:0]     iss_q2,
    input  logic                 cdb_valid,
    input  logic [ROB_W-1:0]     cdb_tag,
    input  logic [DATA_W-1:0]    cdb_data,
    input  logic                 flush,
    output logic                 ex_valid,
    output logic [3:0]           ex_func,
    output logic [DATA_W-1:0]    ex_rs1_data,
    output logic [DATA_W-1:0]    ex_rs2_data,
    output logic [ROB_W-1:0]     ex_rob_ind,
    output logic [RD_W-1:0]      ex_rd,
    output logic                 ex_busy,
    output logic [CNT_OUT_W-1:0] rs_count
`ifdef RS_STATS_EN
    ,
    output logic [15:0]          stat_dispatched,
    output logic [15:0]          stat_stall
`endif
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    typedef struct packed {
        logic              valid;
        logic [3:0]        func;
        logic [RD_W-1:0]   rd;
        logic [ROB_W-1:0]  rob;
        logic              r1ok;
        logic [DATA_W-1:0] v1;
        logic [ROB_W-1:0]  q1;
        logic              r2ok;
        logic [DATA_W-1:0] v2;
        logic [ROB_W-1:0]  q2;
    } slot_t;

    slot_t              ent [NUM_RS];
    logic [NUM_RS-1:0]  valid_vec;
    logic [NUM_RS-1:0]  ready_vec;
    logic [NUM_RS-1:0]  alloc_oh;
    logic [NUM_RS-1:0]  grant;
    logic [NUM_RS-1:0]  dispatch_oh;
    logic [NUM_RS-1:0]  live;
    logic               issue_fire;
    logic               dispatch_fire;
    logic [CNT_W-1:0]   busy_cnt;
    logic               byp1_ok;
    logic               byp2_ok;
    logic [DATA_W-1:0]  byp1_v;
    logic [DATA_W-1:0]  byp2_v;
    slot_t              sel;

    function automatic logic [CNT_W-1:0] lat_of(input logic [3:0] f);
        case (f)
            FUNC_ADD, FUNC_SUB: lat_of = CNT_W'(1);
            FUNC_MUL:           lat_of = CNT_W'(MUL_LAT);
            FUNC_DIV:           lat_of = CNT_W'(DIV_LAT);
            default:            lat_of = CNT_W'(1);
        endcase
    endfunction

    // Occupancy and readiness come only from registered state, so an
    // operand captured at one edge makes its op eligible at the next.
    always_comb begin
        valid_vec = '0;
        ready_vec = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            valid_vec[i] = ent[i].valid;
            ready_vec[i] = ent[i].valid && ent[i].r1ok && ent[i].r2ok;
        end
    end

    // Lowest free slot. A slot freed by this edge's dispatch still reads as
    // valid, so it is not reused until the following cycle.
    assign alloc_oh   = ~valid_vec & (valid_vec + NUM_RS'(1));
    assign iss_ready  = !flush && (valid_vec != {NUM_RS{1'b1}});
    assign issue_fire = iss_valid && iss_ready;

    // Dispatch is allowed in the exec unit's last busy cycle so that
    // single-cycle ops stream back to back.
    assign dispatch_fire = !flush && (ready_vec != '0) && (busy_cnt <= CNT_W'(1));
    assign dispatch_oh   = dispatch_fire ? grant : '0;
    assign live          = valid_vec & ~dispatch_oh;
    assign ex_busy       = (busy_cnt != '0);

    // Operands being broadcast on the issue cycle are captured directly.
    assign byp1_ok = iss_r1ok || (cdb_valid && (cdb_tag == iss_q1));
    assign byp2_ok = iss_r2ok || (cdb_valid && (cdb_tag == iss_q2));
    assign byp1_v  = iss_r1ok ? iss_v1 : cdb_data;
    assign byp2_v  = iss_r2ok ? iss_v2 : cdb_data;

    age_select #(.NUM_RS(NUM_RS)) u_age (
        .clk      (clk1),
        .rst_n    (rst_n),
        .alloc    (issue_fire),
        .alloc_oh (alloc_oh),
        .live     (live),
        .ready    (ready_vec),
        .grant    (grant)
    );

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_RS; i++)
            if (grant[i]) sel = ent[i];
    end

    always_comb begin
        rs_count = '0;
        for (int i = 0; i < NUM_RS; i++)
            rs_count = rs_count + CNT_OUT_W'(valid_vec[i]);
    end

    // Entry storage: issue write, dispatch free and CDB snoop. The issue
    // slot is always invalid, so it never collides with dispatch or snoop.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RS; i++) ent[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < NUM_RS; i++) ent[i].valid <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_RS; i++) begin
                if (issue_fire && alloc_oh[i]) begin
                    ent[i].valid <= 1'b1;
                    ent[i].func  <= iss_func;
                    ent[i].rd    <= iss_rd;
                    ent[i].rob   <= iss_rob;
                    ent[i].r1ok  <= byp1_ok;
                    ent[i].v1    <= byp1_v;
                    ent[i].q1    <= iss_q1;
                    ent[i].r2ok  <= byp2_ok;
                    ent[i].v2    <= byp2_v;
                    ent[i].q2    <= iss_q2;
                end else begin
                    if (dispatch_oh[i]) ent[i].valid <= 1'b0;
                    if (ent[i].valid && !ent[i].r1ok && cdb_valid && (ent[i].q1 == cdb_tag)) begin
                        ent[i].r1ok <= 1'b1;
                        ent[i].v1   <= cdb_data;
                    end
                    if (ent[i].valid && !ent[i].r2ok && cdb_valid && (ent[i].q2 == cdb_tag)) begin
                        ent[i].r2ok <= 1'b1;
                        ent[i].v2   <= cdb_data;
                    end
                end
            end
        end
    end

    // Registered dispatch outputs and exec occupancy. The busy counter
    // keeps running through a flush because the exec unit cannot abort.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_func     <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_rob_ind  <= '0;
            ex_rd       <= '0;
            busy_cnt    <= '0;
        end else begin
            ex_valid <= dispatch_fire;
            if (dispatch_fire) begin
                ex_func     <= sel.func;
                ex_rs1_data <= sel.v1;
                ex_rs2_data <= sel.v2;
                ex_rob_ind  <= sel.rob;
                ex_rd       <= sel.rd;
                busy_cnt    <= lat_of(sel.func);
            end else if (busy_cnt != '0) begin
                busy_cnt <= busy_cnt - CNT_W'(1);
            end
        end
    end

`ifdef RS_STATS_EN
    // Saturating statistics; a stall is a cycle where something is ready
    // but the exec unit is still occupied beyond its last cycle.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            stat_dispatched <= '0;
            stat_stall      <= '0;
        end else begin
            if (dispatch_fire && (stat_dispatched != 16'hFFFF))
                stat_dispatched <= stat_dispatched + 16'd1;
            if (!flush && (ready_vec != '0) && (busy_cnt > CNT_W'(1)) && (stat_stall != 16'hFFFF))
                stat_stall <= stat_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rs_dispatch_sched.sv
// ---------------------------------------------------------------------------
// tb_rs_dispatch_sched
// Directed bench for rs_dispatch_sched. Stimulus pushes the expected
// dispatch (fields plus the cycle it must appear in) into a queue; a monitor
// on the falling edge pops and compares every ex_valid pulse.
// ---------------------------------------------------------------------------
module tb_rs_dispatch_sched;
    import tomasulo_pkg::*;

    logic       clk1;
    logic       rst_n;
    logic       iss_valid;
    logic       iss_ready;
    logic [3:0] iss_func;
    logic [3:0] iss_rd;
    logic [2:0] iss_rob;
    logic       iss_r1ok;
    logic       iss_r2ok;
    logic [7:0] iss_v1;
    logic [7:0] iss_v2;
    logic [2:0] iss_q1;
    logic [2:0] iss_q2;
    logic       cdb_valid;
    logic [2:0] cdb_tag;
    logic [7:0] cdb_data;
    logic       flush;
    logic       ex_valid;
    logic [3:0] ex_func;
    logic [7:0] ex_rs1_data;
    logic [7:0] ex_rs2_data;
    logic [2:0] ex_rob_ind;
    logic [3:0] ex_rd;
    logic       ex_busy;
    logic [2:0] rs_count;
`ifdef RS_STATS_EN
    logic [15:0] stat_dispatched;
    logic [15:0] stat_stall;
`endif

    typedef struct {
        logic [3:0] func;
        logic [7:0] v1;
        logic [7:0] v2;
        logic [2:0] rob;
        logic [3:0] rd;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   a;
    int   base;

    rs_dispatch_sched #(
        .NUM_RS(4), .DATA_W(8), .ROB_W(3), .RD_W(4), .MUL_LAT(2), .DIV_LAT(4)
    ) dut (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .iss_valid   (iss_valid),
        .iss_ready   (iss_ready),
        .iss_func    (iss_func),
        .iss_rd      (iss_rd),
        .iss_rob     (iss_rob),
        .iss_r1ok    (iss_r1ok),
        .iss_r2ok    (iss_r2ok),
        .iss_v1      (iss_v1),
        .iss_v2      (iss_v2),
        .iss_q1      (iss_q1),
        .iss_q2      (iss_q2),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .flush       (flush),
        .ex_valid    (ex_valid),
        .ex_func     (ex_func),
        .ex_rs1_data (ex_rs1_data),
        .ex_rs2_data (ex_rs2_data),
        .ex_rob_ind  (ex_rob_ind),
        .ex_rd       (ex_rd),
        .ex_busy     (ex_busy),
        .rs_count    (rs_count)
`ifdef RS_STATS_EN
        ,
        .stat_dispatched (stat_dispatched),
        .stat_stall      (stat_stall)
`endif
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    always @(posedge clk1) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic pushExp(input logic [3:0] f, input logic [7:0] v1, input logic [7:0] v2,
                           input logic [2:0] rob, input logic [3:0] rd, input int c);
        exp_t e;
        e.func = f; e.v1 = v1; e.v2 = v2; e.rob = rob; e.rd = rd; e.cyc = c;
        exp_q.push_back(e);
    endtask

    // Present one op for a single edge; the op must be accepted.
    task automatic applyStimulus(input logic [3:0] f, input logic [3:0] rd, input logic [2:0] rob,
                                 input logic r1ok, input logic [7:0] v1, input logic [2:0] q1,
                                 input logic r2ok, input logic [7:0] v2, input logic [2:0] q2);
        iss_func = f; iss_rd = rd; iss_rob = rob;
        iss_r1ok = r1ok; iss_v1 = v1; iss_q1 = q1;
        iss_r2ok = r2ok; iss_v2 = v2; iss_q2 = q2;
        iss_valid = 1'b1;
        #1;
        checkOutput("issue_ready", iss_ready, 1);
        tick();
        iss_valid = 1'b0;
    endtask

    // Every dispatch pulse must match the oldest outstanding expectation,
    // including the cycle in which it appears.
    always @(negedge clk1) begin
        if (rst_n && ex_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_dispatch: got rob=%0d at cycle %0d expected no dispatch", ex_rob_ind, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("ex_func", ex_func, mon_e.func);
                checkOutput("ex_rs1_data", ex_rs1_data, mon_e.v1);
                checkOutput("ex_rs2_data", ex_rs2_data, mon_e.v2);
                checkOutput("ex_rob_ind", ex_rob_ind, mon_e.rob);
                checkOutput("ex_rd", ex_rd, mon_e.rd);
                checkOutput("dispatch_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; iss_valid = 1'b0;
        iss_func = '0; iss_rd = '0; iss_rob = '0;
        iss_r1ok = 1'b0; iss_r2ok = 1'b0; iss_v1 = '0; iss_v2 = '0; iss_q1 = '0; iss_q2 = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        #1;
        checkOutput("rst_iss_ready", iss_ready, 1);
        checkOutput("rst_ex_valid", ex_valid, 0);
        checkOutput("rst_ex_busy", ex_busy, 0);
        checkOutput("rst_rs_count", rs_count, 0);
        checkOutput("rst_ex_rd", ex_rd, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] test 1: ready ADD");
        applyStimulus(FUNC_ADD, 4'd4, 3'd2, 1, 8'd5, 3'd0, 1, 8'd3, 3'd0);
        a = cyc;
        pushExp(FUNC_ADD, 8'd5, 8'd3, 3'd2, 4'd4, a + 1);
        checkOutput("t1_count_issue", rs_count, 1);
        tick();
        checkOutput("t1_count_dispatch", rs_count, 0);
        checkOutput("t1_busy", ex_busy, 1);
        tick();
        checkOutput("t1_busy_done", ex_busy, 0);

        $display("[TB] test 2: SUB waiting on CDB");
        applyStimulus(FUNC_SUB, 4'd1, 3'd5, 0, 8'd0, 3'd6, 1, 8'd7, 3'd0);
        a = cyc;
        pushExp(FUNC_SUB, 8'h20, 8'd7, 3'd5, 4'd1, a + 3);
        tick();
        checkOutput("t2_waiting_count", rs_count, 1);
        cdb_valid = 1'b1; cdb_tag = 3'd6; cdb_data = 8'h20;
        tick();
        cdb_valid = 1'b0;
        tick();
        checkOutput("t2_count_after", rs_count, 0);
        tick();

        $display("[TB] test 3: DIV then ADD");
        applyStimulus(FUNC_DIV, 4'd2, 3'd3, 1, 8'd100, 3'd0, 1, 8'd0, 3'd0);
        a = cyc;
        pushExp(FUNC_DIV, 8'd100, 8'd0, 3'd3, 4'd2, a + 1);
        applyStimulus(FUNC_ADD, 4'd3, 3'd4, 1, 8'd1, 3'd0, 1, 8'd2, 3'd0);
        pushExp(FUNC_ADD, 8'd1, 8'd2, 3'd4, 4'd3, a + 5);
        for (int k = 0; k < 5; k++) begin
            checkOutput("t3_busy", ex_busy, 1);
            tick();
        end
        checkOutput("t3_busy_clear", ex_busy, 0);
`ifdef RS_STATS_EN
        checkOutput("t3_stat_stall", stat_stall, 3);
        checkOutput("t3_stat_dispatched", stat_dispatched, 4);
`endif

        $display("[TB] test 4: fill, wake, in-order dispatch");
        base = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus((i % 2 == 1) ? FUNC_SUB : FUNC_ADD, 4'(8 + i), 3'(2 + i),
                          0, 8'd0, 3'd1, 1, 8'(10 + i), 3'd0);
            if (i == 0) base = cyc;
            pushExp((i % 2 == 1) ? FUNC_SUB : FUNC_ADD, 8'h11, 8'(10 + i), 3'(2 + i), 4'(8 + i), base + 6 + i);
        end
        checkOutput("t4_full_ready", iss_ready, 0);
        checkOutput("t4_full_count", rs_count, 4);
        iss_func = FUNC_ADD; iss_rd = 4'd15; iss_rob = 3'd7;
        iss_r1ok = 1'b1; iss_r2ok = 1'b1; iss_v1 = 8'hAA; iss_v2 = 8'hBB;
        iss_valid = 1'b1;
        tick();
        iss_valid = 1'b0;
        checkOutput("t4_ignored_count", rs_count, 4);
        cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_data = 8'h11;
        tick();
        cdb_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        checkOutput("t4_drained", rs_count, 0);
        tick(); tick();

        $display("[TB] test 5: issue bypass");
        cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_data = 8'd9;
        applyStimulus(FUNC_MUL, 4'd5, 3'd6, 1, 8'h40, 3'd0, 0, 8'd0, 3'd3);
        cdb_valid = 1'b0;
        a = cyc;
        pushExp(FUNC_MUL, 8'h40, 8'd9, 3'd6, 4'd5, a + 1);
        tick();
        checkOutput("t5_busy_a", ex_busy, 1);
        tick();
        checkOutput("t5_busy_b", ex_busy, 1);
        tick();
        checkOutput("t5_busy_done", ex_busy, 0);

        $display("[TB] test 6: flush with MUL in flight, then reset");
        for (int i = 0; i < 3; i++)
            applyStimulus(FUNC_ADD, 4'(i), 3'(i), 0, 8'd0, 3'd7, 1, 8'(i), 3'd0);
        applyStimulus(FUNC_MUL, 4'd12, 3'd1, 1, 8'd3, 3'd0, 1, 8'd4, 3'd0);
        a = cyc;
        pushExp(FUNC_MUL, 8'd3, 8'd4, 3'd1, 4'd12, a + 1);
        tick();
        checkOutput("t6_count_pre_flush", rs_count, 3);
        flush = 1'b1;
        iss_func = FUNC_ADD; iss_rd = 4'd6; iss_rob = 3'd6;
        iss_r1ok = 1'b1; iss_r2ok = 1'b1; iss_v1 = 8'd1; iss_v2 = 8'd1;
        iss_valid = 1'b1;
        #1;
        checkOutput("t6_ready_flush", iss_ready, 0);
        tick();
        flush = 1'b0; iss_valid = 1'b0;
        checkOutput("t6_count_flushed", rs_count, 0);
        checkOutput("t6_busy_kept", ex_busy, 1);
        tick();
        checkOutput("t6_busy_done", ex_busy, 0);
        checkOutput("t6_no_dispatch", ex_valid, 0);

        applyStimulus(FUNC_ADD, 4'd1, 3'd2, 0, 8'd0, 3'd7, 1, 8'd0, 3'd0);
        applyStimulus(FUNC_MUL, 4'd9, 3'd5, 1, 8'h55, 3'd0, 1, 8'h66, 3'd0);
        a = cyc;
        pushExp(FUNC_MUL, 8'h55, 8'h66, 3'd5, 4'd9, a + 1);
        tick();
        checkOutput("t6_mul_busy", ex_busy, 1);
        checkOutput("t6_mul_count", rs_count, 1);
        @(negedge clk1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_ex_valid", ex_valid, 0);
        checkOutput("t6_rst_busy", ex_busy, 0);
        checkOutput("t6_rst_count", rs_count, 0);
        checkOutput("t6_rst_rs1", ex_rs1_data, 0);
        checkOutput("t6_rst_rob", ex_rob_ind, 0);
        checkOutput("t6_rst_func", ex_func, 0);
        checkOutput("t6_rst_ready", iss_ready, 1);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        checkOutput("end_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
